// File: rtl/flip_select_controller.sv
// flip_select_controller: sequences one variable-flip selection for an
// unsatisfied clause. Reads the clause-broken/mask words for each of the
// three literals, stages them into the flip selector with the 01/10/11
// write-enable sequence, then reports the selected variable.
// Optional build macro FLIP_CTRL_LFSR_EN: the random word fed to the
// selector comes from an internal Galois LFSR instead of random_i.
module flip_select_controller #(
    parameter int MAX_CLAUSES_PER_VARIABLE = 20,
    parameter int NSAT                     = 3,
    parameter int VAR_BITS                 = 12,
    parameter int MEM_LATENCY              = 1
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                start_i,
    input  logic [NSAT*VAR_BITS-1:0]            lits_i,
    input  logic                                abort_i,
    input  logic [31:0]                         random_i,
    output logic                                busy_o,
    output logic                                done_o,
    output logic                                no_flip_o,
    output logic [VAR_BITS-1:0]                 flip_var_o,
    output logic [1:0]                          flip_idx_o,
    output logic [MAX_CLAUSES_PER_VARIABLE-1:0] clause_valid_bits_o,
    output logic                                rd_en_o,
    output logic [VAR_BITS-1:0]                 rd_addr_o,
    input  logic [2*MAX_CLAUSES_PER_VARIABLE-1:0] rd_data_i,
    output logic [1:0]                          sel_wr_en_o,
    output logic [MAX_CLAUSES_PER_VARIABLE-1:0] sel_clause_broken_o,
    output logic [MAX_CLAUSES_PER_VARIABLE-1:0] sel_mask_bits_o,
    output logic [NSAT-1:0]                     sel_valid_o,
    output logic [31:0]                         sel_random_o,
    input  logic [1:0]                          sel_selected_i,
    input  logic [MAX_CLAUSES_PER_VARIABLE-1:0] sel_clause_valid_bits_i
);

    localparam int MC = MAX_CLAUSES_PER_VARIABLE;
    localparam int CW = $clog2(MEM_LATENCY + 4);

    if (NSAT != 3) begin : g_nsat_check
        $error("flip_select_controller supports NSAT == 3 only");
    end
    if (MEM_LATENCY < 1 || MEM_LATENCY > 4) begin : g_lat_check
        $error("flip_select_controller supports MEM_LATENCY 1..4 only");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_SELECT,
        S_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic [NSAT*VAR_BITS-1:0]   lits_q;
    logic [NSAT-1:0]            valid_q;
    logic                       nf_q;
    logic                       abort_q, abort_d;
    logic [1:0]                 issue_cnt_q, issue_cnt_d;
    logic [1:0]                 rtn_idx_q;
    logic [CW-1:0]              inflight_q, inflight_d;
    logic [MEM_LATENCY-1:0]     rtn_pipe_q;
    logic [MC-1:0]              stage_cb_q, stage_mask_q;
    logic [1:0]                 wr_en_q;
    logic [1:0]                 res_idx_q;
    logic [VAR_BITS-1:0]        res_var_q;
    logic [MC-1:0]              res_cvb_q;

    logic                       busy, rd_en, rtn_vld, take, accept, in_done;
    logic [1:0]                 sel_idx_c, res_idx_c;
    logic [VAR_BITS-1:0]        res_var_c;
    logic [MC-1:0]              res_cvb_c;

    function automatic logic [VAR_BITS-1:0] lit_at(input logic [NSAT*VAR_BITS-1:0] l,
                                                   input logic [1:0] k);
        case (k)
            2'd1:    return l[VAR_BITS +: VAR_BITS];
            2'd2:    return l[2*VAR_BITS +: VAR_BITS];
            default: return l[0 +: VAR_BITS];
        endcase
    endfunction

    assign busy    = (state_q != S_IDLE);
    assign rd_en   = (state_q == S_ISSUE);
    assign in_done = (state_q == S_DONE);
    assign accept  = start_i && (state_q == S_IDLE);
    assign rtn_vld = rtn_pipe_q[MEM_LATENCY-1];
    // A return is only staged while the operation is live; abort discards it.
    assign take    = rtn_vld && !abort_q && !abort_i;

    // In-flight read counter: +1 per issued read, -1 per return, saturating.
    always_comb begin
        inflight_d = inflight_q;
        if (rd_en && !rtn_vld) begin
            if (inflight_q != '1) inflight_d = inflight_q + CW'(1);
        end else if (!rd_en && rtn_vld) begin
            if (inflight_q != '0) inflight_d = inflight_q - CW'(1);
        end
    end

    // Next-state logic for the selection sequence.
    always_comb begin
        state_d     = state_q;
        abort_d     = abort_q;
        issue_cnt_d = issue_cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d     = (lits_i == '0) ? S_DONE : S_ISSUE;
                    issue_cnt_d = '0;
                end
            end
            S_ISSUE: begin
                issue_cnt_d = issue_cnt_q + 2'd1;
                if (abort_i) begin
                    state_d = S_DRAIN;
                    abort_d = 1'b1;
                end else if (issue_cnt_q == 2'd2) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (abort_q || abort_i) begin
                    abort_d = 1'b1;
                    if (inflight_d == '0) state_d = S_IDLE;
                end else if (take && rtn_idx_q == 2'd2) begin
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                if (abort_i) begin
                    abort_d = 1'b1;
                    state_d = (inflight_d == '0) ? S_IDLE : S_DRAIN;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_IDLE) abort_d = 1'b0;
    end

    // Result selection; an invalid selector code falls back to literal 0.
    always_comb begin
        sel_idx_c = (sel_selected_i == 2'b11) ? 2'b00 : sel_selected_i;
        res_idx_c = nf_q ? 2'b00 : sel_idx_c;
        res_var_c = nf_q ? '0 : lit_at(lits_q, res_idx_c);
        res_cvb_c = nf_q ? '0 : sel_clause_valid_bits_i;
    end

    // State, staging, counters and held results.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            lits_q       <= '0;
            valid_q      <= '0;
            nf_q         <= 1'b0;
            abort_q      <= 1'b0;
            issue_cnt_q  <= '0;
            rtn_idx_q    <= '0;
            inflight_q   <= '0;
            rtn_pipe_q   <= '0;
            stage_cb_q   <= '0;
            stage_mask_q <= '0;
            wr_en_q      <= '0;
            res_idx_q    <= '0;
            res_var_q    <= '0;
            res_cvb_q    <= '0;
        end else begin
            state_q     <= state_d;
            abort_q     <= abort_d;
            issue_cnt_q <= issue_cnt_d;
            inflight_q  <= inflight_d;
            rtn_pipe_q[0] <= rd_en;
            for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
                rtn_pipe_q[i] <= rtn_pipe_q[i-1];
            end
            if (accept) begin
                lits_q    <= lits_i;
                valid_q   <= {lits_i[2*VAR_BITS +: VAR_BITS] != '0,
                              lits_i[VAR_BITS +: VAR_BITS] != '0,
                              lits_i[0 +: VAR_BITS] != '0};
                nf_q      <= (lits_i == '0);
                rtn_idx_q <= '0;
            end else if (take) begin
                rtn_idx_q <= rtn_idx_q + 2'd1;
            end
            if (take) begin
                stage_cb_q   <= rd_data_i[MC-1:0];
                stage_mask_q <= rd_data_i[2*MC-1:MC];
            end
            // Write-enable code for return k is k+1, presented the cycle after capture.
            wr_en_q <= take ? (rtn_idx_q + 2'd1) : 2'b00;
            if (in_done) begin
                res_idx_q <= res_idx_c;
                res_var_q <= res_var_c;
                res_cvb_q <= res_cvb_c;
            end
        end
    end

`ifdef FLIP_CTRL_LFSR_EN
    logic [31:0] lfsr_q;
    logic        unused_random;
    assign unused_random = ^random_i;

    // Galois LFSR, advancing only while an operation is in progress.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_q <= 32'h1;
        end else if (busy) begin
            lfsr_q <= lfsr_q[0] ? ((lfsr_q >> 1) ^ 32'h80200003) : (lfsr_q >> 1);
        end
    end
    assign sel_random_o = lfsr_q;
`else
    logic [31:0] rand_q;

    // External random word, registered once on its way to the selector.
    always_ff @(posedge clk_i) begin
        if (rst_i) rand_q <= '0;
        else       rand_q <= random_i;
    end
    assign sel_random_o = rand_q;
`endif

    assign busy_o              = busy;
    assign done_o              = in_done;
    assign no_flip_o           = in_done && nf_q;
    assign flip_idx_o          = in_done ? res_idx_c : res_idx_q;
    assign flip_var_o          = in_done ? res_var_c : res_var_q;
    assign clause_valid_bits_o = in_done ? res_cvb_c : res_cvb_q;
    assign rd_en_o             = rd_en;
    assign rd_addr_o           = rd_en ? lit_at(lits_q, issue_cnt_q) : '0;
    assign sel_wr_en_o         = wr_en_q;
    assign sel_clause_broken_o = stage_cb_q;
    assign sel_mask_bits_o     = stage_mask_q;
    assign sel_valid_o         = busy ? valid_q : '0;

endmodule

// File: tb/tb_flip_select_controller.sv
// Bench for flip_select_controller: three instances at memory latency 1, 2
// and 3 share stimulus; each has its own memory model and scoreboard.
module tb_flip_select_controller;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [35:0] lits;
    logic [31:0] rnd;
    logic [1:0]  sel_sel;
    logic [19:0] sel_cvb;

    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;

    logic [11:0] exp_var;
    logic [1:0]  exp_idx;
    logic        exp_nf;
    logic [2:0]  exp_valid;
    logic [19:0] exp_cvb;

    typedef struct {
        int unsigned cyc;
        logic [11:0] addr;
    } rd_ev_t;

    typedef struct {
        int unsigned cyc;
        logic [1:0]  code;
        logic [19:0] cb;
        logic [19:0] mask;
        logic [2:0]  vld;
    } wr_ev_t;

    typedef struct {
        int unsigned cyc;
        logic        nf;
        logic [11:0] v;
        logic [1:0]  idx;
        logic [19:0] cvb;
        logic [2:0]  vld;
    } dn_ev_t;

    typedef struct {
        logic [11:0] l0, l1, l2;
        logic [1:0]  sel;
        logic [19:0] cvb;
        logic [11:0] ev;
        logic [1:0]  eidx;
        logic        enf;
        logic [2:0]  evld;
    } vec_t;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) begin
        #1 rnd = $urandom();
    end

    function automatic logic [19:0] mem_cb(input logic [11:0] a);
        return {8'hC3, a};
    endfunction

    function automatic logic [19:0] mem_mask(input logic [11:0] a);
        return {a ^ 12'h5A5, 8'h3C};
    endfunction

    task automatic chk(input int inst, input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL inst%0d %s actual=%0h required=%0h", inst, nm, act, req);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_l
        localparam int unsigned L = gi + 1;

        logic        busy, done, nf, rden;
        logic [11:0] fvar, raddr;
        logic [1:0]  fidx, wr;
        logic [19:0] cvb, scb, smask;
        logic [2:0]  sval;
        logic [31:0] srand, rand_exp;
        logic [39:0] rdata;
        logic [11:0] mpipe [L];
        rd_ev_t      rdq[$];
        wr_ev_t      wrq[$];
        dn_ev_t      dnq[$];
        int unsigned pend = 0;

        always @(posedge clk) begin
            mpipe[0] <= raddr;
            for (int i = 1; i < int'(L); i++) mpipe[i] <= mpipe[i-1];
        end
        assign rdata = {mem_mask(mpipe[L-1]), mem_cb(mpipe[L-1])};

        always @(posedge clk) rand_exp <= rst ? 32'h0 : rnd;

        flip_select_controller #(
            .MAX_CLAUSES_PER_VARIABLE(20),
            .NSAT(3),
            .VAR_BITS(12),
            .MEM_LATENCY(L)
        ) u_dut (
            .clk_i(clk),
            .rst_i(rst),
            .start_i(start),
            .lits_i(lits),
            .abort_i(abort),
            .random_i(rnd),
            .busy_o(busy),
            .done_o(done),
            .no_flip_o(nf),
            .flip_var_o(fvar),
            .flip_idx_o(fidx),
            .clause_valid_bits_o(cvb),
            .rd_en_o(rden),
            .rd_addr_o(raddr),
            .rd_data_i(rdata),
            .sel_wr_en_o(wr),
            .sel_clause_broken_o(scb),
            .sel_mask_bits_o(smask),
            .sel_valid_o(sval),
            .sel_random_o(srand),
            .sel_selected_i(sel_sel),
            .sel_clause_valid_bits_i(sel_cvb)
        );

        always @(negedge clk) begin
            rd_ev_t      r;
            wr_ev_t      w;
            dn_ev_t      d;
            logic [11:0] lk;
            if (rden) begin
                if (rdq.size() == 0) chk(gi, "rd_spurious", 1, 0);
                else begin
                    r = rdq.pop_front();
                    chk(gi, "rd_cycle", 64'(cyc), 64'(r.cyc));
                    chk(gi, "rd_addr", 64'(raddr), 64'(r.addr));
                end
            end
            if (wr != 2'b00) begin
                if (wrq.size() == 0) chk(gi, "wr_spurious", 64'(wr), 0);
                else begin
                    w = wrq.pop_front();
                    chk(gi, "wr_cycle", 64'(cyc), 64'(w.cyc));
                    chk(gi, "wr_code", 64'(wr), 64'(w.code));
                    chk(gi, "wr_cb", 64'(scb), 64'(w.cb));
                    chk(gi, "wr_mask", 64'(smask), 64'(w.mask));
                    chk(gi, "sel_valid", 64'(sval), 64'(w.vld));
                end
            end
            if (done) begin
                if (dnq.size() == 0) chk(gi, "done_spurious", 1, 0);
                else begin
                    d = dnq.pop_front();
                    chk(gi, "done_cycle", 64'(cyc), 64'(d.cyc));
                    chk(gi, "no_flip", 64'(nf), 64'(d.nf));
                    chk(gi, "done_valid", 64'(sval), 64'(d.vld));
                    if (!d.nf) begin
                        chk(gi, "flip_var", 64'(fvar), 64'(d.v));
                        chk(gi, "flip_idx", 64'(fidx), 64'(d.idx));
                        chk(gi, "clause_valid", 64'(cvb), 64'(d.cvb));
                    end
                end
            end
`ifndef FLIP_CTRL_LFSR_EN
            chk(gi, "sel_random", 64'(srand), 64'(rand_exp));
`endif
            if (rst || (abort && busy && !done)) begin
                rdq.delete();
                wrq.delete();
                dnq.delete();
            end
            if (start && !busy && !rst) begin
                if (lits == 36'h0) begin
                    d = '{cyc + 1, 1'b1, 12'h0, 2'b00, 20'h0, 3'b000};
                    dnq.push_back(d);
                end else begin
                    for (int unsigned k = 0; k < 3; k++) begin
                        lk = lits[k*12 +: 12];
                        r.cyc  = cyc + 1 + k;
                        r.addr = lk;
                        rdq.push_back(r);
                        w.cyc  = cyc + 2 + k + L;
                        w.code = 2'(k + 1);
                        w.cb   = mem_cb(lk);
                        w.mask = mem_mask(lk);
                        w.vld  = exp_valid;
                        wrq.push_back(w);
                    end
                    d.cyc = cyc + 5 + L;
                    d.nf  = exp_nf;
                    d.v   = exp_var;
                    d.idx = exp_idx;
                    d.cvb = exp_cvb;
                    d.vld = exp_valid;
                    dnq.push_back(d);
                end
            end
            pend = rdq.size() + wrq.size() + dnq.size();
        end
    end

    logic [2:0] busy_all, done_all, wr_any, idx_any;
    assign busy_all = {g_l[2].busy, g_l[1].busy, g_l[0].busy};
    assign done_all = {g_l[2].done, g_l[1].done, g_l[0].done};
    assign wr_any   = {|g_l[2].wr, |g_l[1].wr, |g_l[0].wr};
    assign idx_any  = {|g_l[2].fidx, |g_l[1].fidx, |g_l[0].fidx};

    vec_t tbl [6];

    // Called just after a rising edge; drives start for one cycle (cycle 0).
    task automatic run_vec(input vec_t v);
        sel_sel   = v.sel;
        sel_cvb   = v.cvb;
        exp_var   = v.ev;
        exp_idx   = v.eidx;
        exp_nf    = v.enf;
        exp_valid = v.evld;
        exp_cvb   = v.cvb;
        lits      = {v.l2, v.l1, v.l0};
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic check_quiet(input string nm);
        @(negedge clk);
        #1;
        chk(3, {nm, "_pending"}, 64'(g_l[0].pend + g_l[1].pend + g_l[2].pend), 0);
        chk(3, {nm, "_idle"}, 64'(busy_all), 0);
    endtask

    initial begin
        logic [2:0] exp_busy;
        tbl[0] = '{12'd5,    12'd9,   12'd12,   2'd1, 20'h00F0F, 12'd9,    2'd1, 1'b0, 3'b111};
        tbl[1] = '{12'd0,    12'd0,   12'd0,    2'd2, 20'h00000, 12'd0,    2'd0, 1'b1, 3'b000};
        tbl[2] = '{12'd7,    12'd0,   12'd3,    2'd2, 20'h12345, 12'd3,    2'd2, 1'b0, 3'b101};
        tbl[3] = '{12'd100,  12'd200, 12'd4095, 2'd3, 20'hABCDE, 12'd100,  2'd0, 1'b0, 3'b111};
        tbl[4] = '{12'd4095, 12'd1,   12'd2,    2'd0, 20'hFFFFF, 12'd4095, 2'd0, 1'b0, 3'b111};
        tbl[5] = '{12'd0,    12'd0,   12'd8,    2'd2, 20'h00001, 12'd8,    2'd2, 1'b0, 3'b100};

        rst = 1'b1; start = 1'b0; abort = 1'b0; lits = '0; rnd = '0;
        sel_sel = '0; sel_cvb = '0;
        exp_var = '0; exp_idx = '0; exp_nf = 1'b0; exp_valid = '0; exp_cvb = '0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk(3, "rst_busy", 64'(busy_all), 0);
        chk(3, "rst_done", 64'(done_all), 0);
        chk(3, "rst_wr_en", 64'(wr_any), 0);
        chk(3, "rst_flip_idx", 64'(idx_any), 0);

        foreach (tbl[i]) begin
            @(posedge clk);
            #1 run_vec(tbl[i]);
            repeat (12) @(posedge clk);
            check_quiet("vec");
        end

        // Abort in cycle 2; a start during the drain must be ignored.
        @(posedge clk);
        #1 run_vec(tbl[0]);
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        start = 1'b1;
        @(negedge clk);
        chk(3, "abort_busy_c3", 64'(busy_all), 64'(3'b111));
        for (int j = 4; j <= 6; j++) begin
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            for (int i = 0; i < 3; i++) exp_busy[i] = (j < 4 + i);
            chk(3, "abort_busy_drain", 64'(busy_all), 64'(exp_busy));
        end
        repeat (8) @(posedge clk);
        check_quiet("abort");

        // Abort while idle has no effect.
        @(posedge clk);
        #1 abort = 1'b1;
        @(negedge clk);
        chk(3, "idle_abort_busy", 64'(busy_all), 0);
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk(3, "idle_abort_after", 64'(busy_all | done_all), 0);

        // Abort in cycle 6: completes for L=1 (done wins), cancels L=2/L=3.
        @(posedge clk);
        #1 run_vec(tbl[0]);
        repeat (5) @(posedge clk);
        #1 abort = 1'b1;
        @(negedge clk);
        chk(3, "abort_vs_done", 64'(done_all), 64'(3'b001));
        @(posedge clk);
        #1 abort = 1'b0;
        repeat (10) @(posedge clk);
        check_quiet("abort_done");

        // Reset in cycle 3, then a fresh operation straight after.
        @(posedge clk);
        #1 run_vec(tbl[2]);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        run_vec(tbl[0]);
        repeat (12) @(posedge clk);
        check_quiet("reset_rerun");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
